// File: rtl/itch_encoder.sv
// itch_encoder: serializes one canonical parsed order-book record per
// handshake into a big-endian ITCH 5.0 byte stream, one byte per cycle,
// with valid/ready backpressure on the output.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   in_valid/in_ready          record handshake
//   parsed_type    1=A 2=X 3=D 4=U 5=E 6=P, anything else is dropped
//   order_ref, side, shares, price, new_order_ref, timestamp, misc_data
//                  record fields, captured on acceptance
//   out_byte/out_valid/out_ready  byte stream handshake
//   out_sop/out_eop            first/last byte markers (qualified by out_valid)
//   drop_err       one-cycle pulse after an unsupported record is accepted
//   msg_count      messages fully transmitted (wraps)
module itch_encoder #(
  parameter logic [15:0] STOCK_LOCATE = 16'h0000,
  parameter logic [15:0] TRACKING_NUM = 16'h0000,
  parameter logic [7:0]  STOCK_FILL   = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  parsed_type,
  input  logic [63:0] order_ref,
  input  logic        side,
  input  logic [31:0] shares,
  input  logic [31:0] price,
  input  logic [63:0] new_order_ref,
  input  logic [47:0] timestamp,
  input  logic [63:0] misc_data,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic        drop_err,
  output logic [15:0] msg_count
);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  state_t      state;
  logic [5:0]  idx;
  logic [3:0]  typ_l;
  logic [63:0] oref_l;
  logic        side_l;
  logic [31:0] shares_l;
  logic [31:0] price_l;
  logic [63:0] nref_l;
  logic [47:0] ts_l;
  logic [63:0] misc_l;

  function automatic logic supported(input logic [3:0] t);
    return (t >= 4'd1) && (t <= 4'd6);
  endfunction

  function automatic logic [5:0] msg_len(input logic [3:0] t);
    logic [5:0] n;
    case (t)
      4'd1:    n = 6'd36;
      4'd2:    n = 6'd23;
      4'd3:    n = 6'd19;
      4'd4:    n = 6'd35;
      4'd5:    n = 6'd31;
      4'd6:    n = 6'd44;
      default: n = 6'd0;
    endcase
    return n;
  endfunction

  // The whole message is laid out MSB-first in a 44-byte vector (zero padded
  // past LEN) so a single left shift by the byte index selects byte[i].
  function automatic logic [7:0] msg_byte(
    input logic [3:0]  t,
    input logic [63:0] oref,
    input logic        sd,
    input logic [31:0] sh,
    input logic [31:0] pr,
    input logic [63:0] nref,
    input logic [47:0] ts,
    input logic [63:0] misc,
    input logic [5:0]  i
  );
    logic [351:0] m;
    logic [87:0]  hdr;
    logic [7:0]   tc;
    logic [7:0]   sc;
    sc = sd ? 8'h42 : 8'h53;
    case (t)
      4'd1:    tc = 8'h41;
      4'd2:    tc = 8'h58;
      4'd3:    tc = 8'h44;
      4'd4:    tc = 8'h55;
      4'd5:    tc = 8'h45;
      4'd6:    tc = 8'h50;
      default: tc = 8'h00;
    endcase
    hdr = {tc, STOCK_LOCATE, TRACKING_NUM, ts};
    case (t)
      4'd1:    m = {hdr, oref, sc, sh, misc, pr, 64'd0};
      4'd2:    m = {hdr, oref, sh, 168'd0};
      4'd3:    m = {hdr, oref, 200'd0};
      4'd4:    m = {hdr, misc, nref, sh, pr, 72'd0};
      4'd5:    m = {hdr, oref, sh, misc, 104'd0};
      4'd6:    m = {hdr, oref, sc, sh, {8{STOCK_FILL}}, pr, misc};
      default: m = '0;
    endcase
    m = m << {i, 3'b000};
    return m[351:344];
  endfunction

  // Combinational so that it is low for the whole reset and high on the
  // first idle cycle after release.
  assign in_ready = (state == S_IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      typ_l     <= '0;
      oref_l    <= '0;
      side_l    <= 1'b0;
      shares_l  <= '0;
      price_l   <= '0;
      nref_l    <= '0;
      ts_l      <= '0;
      misc_l    <= '0;
      out_byte  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      drop_err  <= 1'b0;
      msg_count <= '0;
    end else begin
      drop_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            if (supported(parsed_type)) begin
              typ_l     <= parsed_type;
              oref_l    <= order_ref;
              side_l    <= side;
              shares_l  <= shares;
              price_l   <= price;
              nref_l    <= new_order_ref;
              ts_l      <= timestamp;
              misc_l    <= misc_data;
              idx       <= '0;
              // Byte 0 is built straight from the inputs so it is presented
              // the cycle after acceptance.
              out_byte  <= msg_byte(parsed_type, order_ref, side, shares, price,
                                    new_order_ref, timestamp, misc_data, 6'd0);
              out_valid <= 1'b1;
              out_sop   <= 1'b1;
              out_eop   <= 1'b0;
              state     <= S_SEND;
            end else begin
              drop_err <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (out_ready) begin
            idx <= idx + 6'd1;
            if (out_eop) begin
              out_valid <= 1'b0;
              out_sop   <= 1'b0;
              out_eop   <= 1'b0;
              msg_count <= msg_count + 16'd1;
              state     <= S_IDLE;
            end else begin
              out_byte <= msg_byte(typ_l, oref_l, side_l, shares_l, price_l,
                                   nref_l, ts_l, misc_l, idx + 6'd1);
              out_sop  <= 1'b0;
              out_eop  <= ((idx + 6'd2) == msg_len(typ_l));
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_itch_encoder.sv
module tb_itch_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  parsed_type;
  logic [63:0] order_ref;
  logic        side;
  logic [31:0] shares;
  logic [31:0] price;
  logic [63:0] new_order_ref;
  logic [47:0] timestamp;
  logic [63:0] misc_data;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic        drop_err;
  logic [15:0] msg_count;

  always #5 clk = ~clk;

  itch_encoder #(
    .STOCK_LOCATE(16'h0000),
    .TRACKING_NUM(16'h0000),
    .STOCK_FILL  (8'h20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .parsed_type  (parsed_type),
    .order_ref    (order_ref),
    .side         (side),
    .shares       (shares),
    .price        (price),
    .new_order_ref(new_order_ref),
    .timestamp    (timestamp),
    .misc_data    (misc_data),
    .out_byte     (out_byte),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .drop_err     (drop_err),
    .msg_count    (msg_count)
  );

  typedef struct {
    logic [3:0]  t;
    logic [63:0] oref;
    logic        sd;
    logic [31:0] sh;
    logic [31:0] pr;
    logic [63:0] nref;
    logic [47:0] ts;
    logic [63:0] misc;
  } rec_t;

  typedef struct {
    rec_t       r;
    int         len;
    int         p0;
    logic [7:0] b0;
    int         p1;
    logic [7:0] b1;
    int         mode;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_count = '0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic rec_t mk(input logic [3:0] t, input logic [63:0] oref, input logic sd,
                              input logic [31:0] sh, input logic [31:0] pr,
                              input logic [63:0] nref, input logic [47:0] ts,
                              input logic [63:0] misc);
    rec_t r;
    r.t = t; r.oref = oref; r.sd = sd; r.sh = sh; r.pr = pr;
    r.nref = nref; r.ts = ts; r.misc = misc;
    return r;
  endfunction

  // Reference model: the message is the list of fields in wire order, each
  // emitted most-significant byte first.
  function automatic void push_be(input logic [63:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) exp_q.push_back(v[8*k +: 8]);
  endfunction

  function automatic void build_exp(input rec_t r);
    logic [7:0] sc;
    sc = r.sd ? 8'h42 : 8'h53;
    exp_q.delete();
    case (r.t)
      4'd1: exp_q.push_back("A");
      4'd2: exp_q.push_back("X");
      4'd3: exp_q.push_back("D");
      4'd4: exp_q.push_back("U");
      4'd5: exp_q.push_back("E");
      default: exp_q.push_back("P");
    endcase
    push_be(64'h0000, 2);
    push_be(64'h0000, 2);
    push_be({16'd0, r.ts}, 6);
    case (r.t)
      4'd1: begin
        push_be(r.oref, 8); exp_q.push_back(sc); push_be({32'd0, r.sh}, 4);
        push_be(r.misc, 8); push_be({32'd0, r.pr}, 4);
      end
      4'd2: begin push_be(r.oref, 8); push_be({32'd0, r.sh}, 4); end
      4'd3: push_be(r.oref, 8);
      4'd4: begin
        push_be(r.misc, 8); push_be(r.nref, 8);
        push_be({32'd0, r.sh}, 4); push_be({32'd0, r.pr}, 4);
      end
      4'd5: begin push_be(r.oref, 8); push_be({32'd0, r.sh}, 4); push_be(r.misc, 8); end
      default: begin
        push_be(r.oref, 8); exp_q.push_back(sc); push_be({32'd0, r.sh}, 4);
        for (int k = 0; k < 8; k++) exp_q.push_back(8'h20);
        push_be({32'd0, r.pr}, 4); push_be(r.misc, 8);
      end
    endcase
  endfunction

  task automatic drive_rec(input rec_t r);
    parsed_type = r.t; order_ref = r.oref; side = r.sd; shares = r.sh;
    price = r.pr; new_order_ref = r.nref; timestamp = r.ts; misc_data = r.misc;
  endtask

  task automatic scramble();
    parsed_type = 4'($urandom); order_ref = {$urandom, $urandom}; side = 1'($urandom);
    shares = $urandom; price = $urandom; new_order_ref = {$urandom, $urandom};
    timestamp = {16'($urandom), $urandom}; misc_data = {$urandom, $urandom};
  endtask

  // Called at posedge+1 in IDLE. mode 0: always ready, 1: ready 1,0,0,1 pattern,
  // 2: random ready.
  task automatic xfer(input rec_t r, input int mode);
    int pos, cyc;
    logic stalled, done, psop, peop;
    logic [7:0] pb;
    build_exp(r);
    got_q.delete();
    chk("in_ready_idle", in_ready, 1);
    drive_rec(r);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    pos = 0; cyc = 0; stalled = 0; done = 0; pb = '0; psop = 0; peop = 0;
    while (!done && cyc < 2000) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      chk("out_valid", out_valid, 1);
      chk("in_ready_busy", in_ready, 0);
      if (stalled) begin
        chk("stall_byte", out_byte, pb);
        chk("stall_sop", out_sop, psop);
        chk("stall_eop", out_eop, peop);
      end
      if (out_ready) begin
        got_q.push_back(out_byte);
        if (pos < exp_q.size()) begin
          chk("byte", out_byte, exp_q[pos]);
          chk("sop", out_sop, pos == 0);
          chk("eop", out_eop, pos == exp_q.size() - 1);
        end else begin
          chk("extra_byte", out_byte, 0);
          chk("extra_byte_seen", 1, 0);
        end
        pos++;
        if (out_eop || pos > 50) done = 1;
      end
      stalled = !out_ready; pb = out_byte; psop = out_sop; peop = out_eop;
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) chk("timeout", 0, 1);
    chk("length", got_q.size(), exp_q.size());
    exp_count = exp_count + 16'd1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("msg_count", msg_count, exp_count);
    @(posedge clk); #1;
  endtask

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t r;
    vecs[0] = '{mk(4'd3, 64'h0102030405060708, 1'b0, 0, 0, 0, 48'h1234, 0), 19, 9, 8'h12, 18, 8'h08, 0};
    vecs[1] = '{mk(4'd1, 64'h11, 1'b1, 100, 32'h000186A0, 0, 48'h1, "AAPL    "), 36, 19, 8'h42, 35, 8'hA0, 0};
    vecs[2] = '{mk(4'd4, 64'hDEAD, 1'b0, 7, 8, 6, 48'h2, 5), 35, 18, 8'h05, 34, 8'h08, 0};
    vecs[3] = '{mk(4'd2, 64'hA1, 1'b0, 32'h500, 0, 0, 48'h3, 0), 23, 0, 8'h58, 21, 8'h05, 0};
    vecs[4] = '{mk(4'd5, 64'h7, 1'b0, 32'h10, 0, 0, 48'h4, 64'hFF), 31, 0, 8'h45, 30, 8'hFF, 0};
    vecs[5] = '{mk(4'd6, 64'h9, 1'b0, 1, 2, 0, 48'h5, 3), 44, 24, 8'h20, 19, 8'h53, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    scramble();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sop", out_sop, 0);
    chk("rst_eop", out_eop, 0);
    chk("rst_byte", out_byte, 0);
    chk("rst_drop", drop_err, 0);
    chk("rst_count", msg_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      xfer(vecs[i].r, vecs[i].mode);
      chk("tbl_len", got_q.size(), vecs[i].len);
      if (got_q.size() > vecs[i].p1 && got_q.size() > vecs[i].p0) begin
        chk("tbl_b0", got_q[vecs[i].p0], vecs[i].b0);
        chk("tbl_b1", got_q[vecs[i].p1], vecs[i].b1);
      end else begin
        chk("tbl_short", got_q.size(), vecs[i].len);
      end
    end

    // Unsupported type: dropped with a single-cycle error pulse.
    drive_rec(mk(4'd9, 64'h1, 1'b1, 1, 1, 1, 48'h1, 1));
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("drop_pulse", drop_err, 1);
    chk("drop_no_valid", out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_clear", drop_err, 0);
    chk("drop_no_valid2", out_valid, 0);
    chk("drop_count", msg_count, exp_count);
    @(posedge clk); #1;
    xfer(mk(4'd2, 64'hCAFE, 1'b1, 32'h12345678, 0, 0, 48'hABCDEF, 0), 0);
    chk("cancel_len", got_q.size(), 23);

    // Reset while byte 10 of an Exec message is presented.
    r = mk(4'd5, 64'h55AA, 1'b0, 32'h77, 0, 0, 48'h999, 64'h1234);
    build_exp(r);
    drive_rec(r);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_byte10", out_byte, exp_q[10]);
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_count = '0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_count", msg_count, 0);
    chk("post_rst_valid", out_valid, 0);
    @(posedge clk); #1;
    xfer(r, 0);

    // Randomized records under random backpressure.
    for (int i = 0; i < 25; i++) begin
      r = mk(4'($urandom_range(1, 6)), {$urandom, $urandom}, 1'($urandom), $urandom, $urandom,
             {$urandom, $urandom}, {16'($urandom), $urandom}, {$urandom, $urandom});
      xfer(r, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/itch_encoder.md
Name: itch_encoder

Overview:
- Transmit-side counterpart of the speculative ITCH parser.
- Accepts one canonical parsed record (same field set the parser emits) per handshake and serializes it into a big-endian ITCH 5.0 byte stream, one byte per cycle, with backpressure.
- Used to regenerate exchange-format traffic for loopback testing and for order-entry/replay paths.

Parameters:
- STOCK_LOCATE, 16'h0000, value emitted in header bytes 1-2.
- TRACKING_NUM, 16'h0000, value emitted in header bytes 3-4.
- STOCK_FILL, 8'h20, byte emitted for each of the 8 stock-symbol bytes of a Trade ('P') message.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  canonical record valid
- in_ready  out  1  encoder can accept a record
- parsed_type  in  4  1=Add 'A', 2=Cancel 'X', 3=Delete 'D', 4=Replace 'U', 5=Exec 'E', 6=Trade 'P'
- order_ref  in  64  order reference (Replace: ignored)
- side  in  1  1=buy 'B' (8'h42), 0=sell 'S' (8'h53)
- shares  in  32  shares / canceled / executed shares
- price  in  32  price
- new_order_ref  in  64  Replace new reference
- timestamp  in  48  header timestamp, emitted for all types
- misc_data  in  64  Add: stock symbol; Trade/Exec: match number; Replace: original order ref
- out_byte  out  8  stream byte
- out_valid  out  1  out_byte valid
- out_ready  in  1  sink accepts byte
- out_sop  out  1  first byte of message (qualified by out_valid)
- out_eop  out  1  last byte of message (qualified by out_valid)
- drop_err  out  1  one-cycle pulse when a record with an unsupported type is accepted
- msg_count  out  16  messages fully transmitted, wraps at 16'hFFFF to 0

Behaviour:
- Reset: in_ready=0 while rst is high. out_valid=0, out_sop=0, out_eop=0, out_byte=0, drop_err=0, msg_count=0. All latched fields=0. State=IDLE.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready with a supported type (1-6): latch all inputs, set byte index idx=0, go to SEND.
  - On an unsupported type (0, 7-15): record discarded, drop_err=1 the next cycle, remain in IDLE.
- State SEND:
  - in_ready=0.
  - out_valid=1. out_byte=byte[idx] of the latched message. out_sop=(idx==0). out_eop=(idx==LEN-1).
  - On out_valid&out_ready: idx increments. If the last byte was accepted, msg_count increments and the state returns to IDLE.
  - While out_ready=0, out_byte, out_sop and out_eop hold stable.
- Latency and throughput:
  - Byte 0 is valid on the cycle after input acceptance.
  - Exactly one IDLE cycle separates messages, so the minimum period is LEN+1 cycles.
- Byte layout: all multi-byte fields are big-endian (MSB first). Common header, bytes 0-10:
  - byte 0: type char.
  - bytes 1-2: STOCK_LOCATE.
  - bytes 3-4: TRACKING_NUM.
  - bytes 5-10: timestamp.
- Per-type body layout (field@first byte offset) and message length LEN:
  - A: order_ref@11, side@19, shares@20, misc_data@24, price@32. LEN=36.
  - X: order_ref@11, shares@19. LEN=23.
  - D: order_ref@11. LEN=19.
  - U: misc_data@11, new_order_ref@19, shares@27, price@31. LEN=35.
  - E: order_ref@11, shares@19, misc_data@23. LEN=31.
  - P: order_ref@11, side@19, shares@20, STOCK_FILL x8@24, price@32, misc_data@36. LEN=44.
- Width rules:
  - idx is 6 bits, which covers the maximum LEN of 44.
  - Input changes during SEND have no effect.
- Reset mid-message: output is immediately quiet (out_valid=0). No partial-message completion after reset deasserts. msg_count is not incremented.
- Simultaneous events: drop_err and message acceptance are mutually exclusive because only one record is accepted per cycle. msg_count wraps without any flag.

Test Plan:
- Delete: type=3, order_ref=64'h0102030405060708, timestamp=48'h0000_0000_1234, out_ready=1 -> 19 bytes: 44,00,00,00,00,00,00,00,00,12,34,01..08. out_sop on byte 0, out_eop on byte 18. msg_count=1.
- Add: type=1, side=1, shares=100, price=32'h0001_86A0, misc_data="AAPL    " -> 36 bytes. Byte 19=42. Bytes 20-23=00,00,00,64. Bytes 32-35=00,01,86,A0.
- Replace: misc_data=5, new_order_ref=6, shares=7, price=8 -> 35 bytes. Byte 0=55. Byte 18=05, byte 26=06, byte 30=07, byte 34=08. order_ref is ignored.
- Backpressure during Trade (type=6): out_ready toggled 1,0,0,1 repeatedly -> out_byte and out_eop stable while stalled. Exactly 44 bytes are transferred. Bytes 24-31=20. in_ready=0 throughout.
- Unsupported type=9 with in_valid -> no out_valid, drop_err pulses for exactly 1 cycle, msg_count unchanged. A following Cancel (type=2) is encoded normally as 23 bytes.
- Reset asserted at byte 10 of an Exec message -> out_valid=0 asynchronously. After release: in_ready=1, msg_count=0, and a new Exec message starts with out_sop at byte 0.
